keyboard_controller: RTL and testbench

//  Sits between KeyboardDriver and the LC-3 memory-mapped I/O bus.

---
 rtl/kbd_pkg.sv | 15 +
 rtl/kbd_fifo.sv | 71 +++++++
 rtl/keyboard_controller.sv | 101 ++++++++++
 tb/tb_keyboard_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and types for the LC-3 keyboard controller:
// KBSR bit positions, bus addresses and the scan-code type.
package kbd_pkg;

  localparam int KBSR_READY = 15;
  localparam int KBSR_IE    = 14;
  localparam int KBSR_OVF   = 13;
  localparam int KBSR_FLUSH = 12;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;

  typedef logic [7:0] scancode_t;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scan-code FIFO with flush. A pop while empty and a push while
// full (with no pop) are ignored; flush overrides both.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  scancode_t        din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output scancode_t        head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  scancode_t        mem [DEPTH];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; empty/count gate every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/keyboard_controller.sv
// LC-3 keyboard controller: edge-detects keypresses into a FIFO and exposes
// them through the KBSR/KBDR memory-mapped registers with an interrupt request.
module keyboard_controller
  import kbd_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  KeyCode,
  input  logic        KeyPress,
  input  logic        SelKBSR,
  input  logic        SelKBDR,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] WrData,
  output logic [15:0] RdData,
  output logic        Irq
);

  logic             key_press_q, key_press_d;
  logic             ie_q, ie_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      rd_data_q, rd_data_d;
  logic             irq_q, irq_d;

  logic             push_edge, rd_kbsr, rd_kbdr, wr_kbsr, flush;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  scancode_t        fifo_head;
  logic [15:0]      kbsr_val;
  logic             unused_wr_bits;

  assign push_edge = KeyPress & ~key_press_q;
  // Status select has priority when both selects are asserted.
  assign rd_kbsr   = Rd & SelKBSR;
  assign rd_kbdr   = Rd & SelKBDR & ~SelKBSR;
  assign wr_kbsr   = Wr & SelKBSR;
  assign flush     = wr_kbsr & WrData[KBSR_FLUSH];

  assign unused_wr_bits = ^{WrData[15], WrData[11:0]};

  kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push_edge),
    .pop   (rd_kbdr),
    .flush (flush),
    .din   (KeyCode),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_comb begin
    kbsr_val              = '0;
    kbsr_val[KBSR_READY]  = ~fifo_empty;
    kbsr_val[KBSR_IE]     = ie_q;
    kbsr_val[KBSR_OVF]    = ovf_q;
    kbsr_val[CNT_W-1:0]   = fifo_count;
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    key_press_d = KeyPress;
    ie_d        = ie_q;
    ovf_d       = ovf_q;
    rd_data_d   = '0;
    irq_d       = ie_q & ~fifo_empty;

    if (wr_kbsr) ie_d = WrData[KBSR_IE];
    if (wr_kbsr && WrData[KBSR_OVF]) ovf_d = 1'b0;
    // A dropped keypress outranks a same-cycle clear so the loss is never hidden.
    if (push_edge && fifo_full && !rd_kbdr && !flush) ovf_d = 1'b1;

    if (rd_kbsr)                     rd_data_d = kbsr_val;
    else if (rd_kbdr && !fifo_empty) rd_data_d = {8'h00, fifo_head};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_press_q <= 1'b0;
      ie_q        <= 1'b0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      key_press_q <= key_press_d;
      ie_q        <= ie_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
      irq_q       <= irq_d;
    end
  end

  assign RdData = rd_data_q;
  assign Irq    = irq_q;

endmodule

// File: tb/tb_keyboard_controller.sv
// Directed bench for keyboard_controller: a queue-based model checked every
// cycle, plus hand-computed register values for each scenario.
module tb_keyboard_controller;

  localparam int DEPTH = 8;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [7:0]  KeyCode = '0;
  logic        KeyPress = 1'b0;
  logic        SelKBSR = 1'b0;
  logic        SelKBDR = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] WrData = '0;
  logic [15:0] RdData;
  logic        Irq;

  int total = 0;
  int bad   = 0;

  keyboard_controller #(.DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .KeyCode  (KeyCode),
    .KeyPress (KeyPress),
    .SelKBSR  (SelKBSR),
    .SelKBDR  (SelKBDR),
    .Rd       (Rd),
    .Wr       (Wr),
    .WrData   (WrData),
    .RdData   (RdData),
    .Irq      (Irq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a byte queue plus IE/OVF bits; outputs lag one cycle.
  byte unsigned mq[$];
  bit           m_ie, m_ovf, m_kp;
  logic [15:0]  exp_rd;
  logic         exp_irq;

  always @(posedge Clk or negedge Reset_n) begin
    bit rs, rdd, ws, psh;
    int n;
    if (!Reset_n) begin
      mq.delete();
      m_ie = 0; m_ovf = 0; m_kp = 0;
      exp_rd = '0; exp_irq = 1'b0;
    end else begin
      rs  = Rd && SelKBSR;
      rdd = Rd && SelKBDR && !SelKBSR;
      ws  = Wr && SelKBSR;
      n   = mq.size();
      exp_irq = m_ie && (n != 0);
      if (rs)
        exp_rd = (16'(n != 0) << 15) | (16'(m_ie) << 14) | (16'(m_ovf) << 13) | 16'(n);
      else if (rdd && n != 0)
        exp_rd = {8'h00, mq[0]};
      else
        exp_rd = '0;
      psh  = KeyPress && !m_kp;
      m_kp = KeyPress;
      if (ws && WrData[13]) m_ovf = 0;
      if (ws) m_ie = WrData[14];
      if (ws && WrData[12]) begin
        mq.delete();
      end else begin
        if (rdd && n != 0) void'(mq.pop_front());
        if (psh) begin
          if (mq.size() < DEPTH) mq.push_back(KeyCode);
          else m_ovf = 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (Reset_n) begin
      check("rd_data_model", RdData, exp_rd);
      check("irq_model", {15'b0, Irq}, {15'b0, exp_irq});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_rd(input bit sr, input bit dr, output logic [15:0] v);
    SelKBSR = sr; SelKBDR = dr; Rd = 1'b1;
    tick();
    Rd = 1'b0; SelKBSR = 1'b0; SelKBDR = 1'b0;
    v = RdData;
  endtask

  task automatic bus_wr(input logic [15:0] d);
    SelKBSR = 1'b1; Wr = 1'b1; WrData = d;
    tick();
    Wr = 1'b0; SelKBSR = 1'b0; WrData = '0;
  endtask

  task automatic press(input logic [7:0] c, input int n);
    KeyCode = c; KeyPress = 1'b1;
    repeat (n) tick();
    KeyPress = 1'b0; KeyCode = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;

    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // 1. reset state
    check("reset_irq", {15'b0, Irq}, 16'h0000);
    bus_rd(1, 0, v); check("reset_kbsr", v, 16'h0000);

    // 2. level held 5 cycles pushes once
    press(8'h1C, 5);
    bus_rd(1, 0, v); check("held_kbsr", v, 16'h8001);
    bus_rd(0, 1, v); check("held_kbdr", v, 16'h001C);
    bus_rd(1, 0, v); check("held_kbsr_after", v, 16'h0000);
    bus_rd(0, 1, v); check("empty_kbdr", v, 16'h0000);
    press(8'h3A, 1);
    bus_rd(1, 1, v); check("both_sel_kbsr", v, 16'h8001);
    bus_rd(1, 0, v); check("both_sel_nopop", v, 16'h8001);
    bus_rd(0, 1, v); check("both_sel_kbdr", v, 16'h003A);

    // 3. interrupt follows Ready one cycle later
    bus_wr(16'h4000);
    check("irq_before_push", {15'b0, Irq}, 16'h0000);
    press(8'h32, 1);
    check("irq_raised", {15'b0, Irq}, 16'h0001);
    bus_rd(0, 1, v); check("irq_kbdr", v, 16'h0032);
    tick();
    check("irq_dropped", {15'b0, Irq}, 16'h0000);
    bus_wr(16'h0000);

    // 4. overflow: 9 pushes into 8 entries
    for (int i = 0; i < DEPTH + 1; i++) press(8'h10 + 8'(i), 1);
    bus_rd(1, 0, v); check("ovf_kbsr", v, 16'hA008);
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(0, 1, v); check("ovf_order", v, 16'h0010 + 16'(i));
    end
    bus_rd(1, 0, v); check("ovf_sticky", v, 16'h2000);
    bus_wr(16'h2000);
    bus_rd(1, 0, v); check("ovf_cleared", v, 16'h0000);

    // 5. push and pop together while full
    for (int i = 0; i < DEPTH; i++) press(8'h20 + 8'(i), 1);
    KeyCode = 8'h55; KeyPress = 1'b1; SelKBDR = 1'b1; Rd = 1'b1;
    tick();
    Rd = 1'b0; SelKBDR = 1'b0; KeyPress = 1'b0; KeyCode = '0;
    check("full_pushpop_rd", RdData, 16'h0020);
    tick();
    bus_rd(1, 0, v); check("full_pushpop_kbsr", v, 16'h8008);
    for (int i = 1; i < DEPTH; i++) begin
      bus_rd(0, 1, v); check("full_pushpop_order", v, 16'h0020 + 16'(i));
    end
    bus_rd(0, 1, v); check("full_pushpop_last", v, 16'h0055);

    // 6. flush beats a simultaneous push
    press(8'h61, 1); press(8'h62, 1); press(8'h63, 1);
    bus_rd(1, 0, v); check("pre_flush_kbsr", v, 16'h8003);
    SelKBSR = 1'b1; Wr = 1'b1; WrData = 16'h1000; KeyCode = 8'h77; KeyPress = 1'b1;
    tick();
    SelKBSR = 1'b0; Wr = 1'b0; WrData = '0; KeyPress = 1'b0; KeyCode = '0;
    tick();
    bus_rd(1, 0, v); check("flush_kbsr", v, 16'h0000);

    // reset in the middle of activity
    bus_wr(16'h4000);
    press(8'hA1, 1); press(8'hA2, 1);
    check("pre_reset_irq", {15'b0, Irq}, 16'h0001);
    KeyCode = 8'hA3; KeyPress = 1'b1; SelKBDR = 1'b1; Rd = 1'b1;
    tick();
    check("pre_reset_rd", RdData, 16'h00A1);
    #2 Reset_n = 1'b0;
    #1;
    check("reset_async_rd", RdData, 16'h0000);
    check("reset_async_irq", {15'b0, Irq}, 16'h0000);
    KeyPress = 1'b0; KeyCode = '0; SelKBDR = 1'b0; Rd = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    bus_rd(1, 0, v); check("post_reset_kbsr", v, 16'h0000);
    check("post_reset_irq", {15'b0, Irq}, 16'h0000);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
